// File: rtl/motion_pkg.sv
// ---------------------------------------------------------------------------
// motion_pkg
// Shared definitions for the motion phase sequencer slice.
//   - Phase encodings published on the sequencer's phase output.
//   - Default timing / parameter word widths.
//   - Vector typedefs for a four-boundary timing profile and the five-word
//     parameter set that belongs to it.
//   - Sequencer state encoding.
// ---------------------------------------------------------------------------
package motion_pkg;

  localparam int TW_DEFAULT = 64;
  localparam int PW_DEFAULT = 32;

  localparam logic [2:0] PH_0    = 3'd0;
  localparam logic [2:0] PH_1    = 3'd1;
  localparam logic [2:0] PH_2    = 3'd2;
  localparam logic [2:0] PH_3    = 3'd3;
  localparam logic [2:0] PH_IDLE = 3'd7;

  typedef logic [TW_DEFAULT-1:0] timing_vec_t [0:3];
  typedef logic [PW_DEFAULT-1:0] param_vec_t  [0:4];

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/motion_phase_sequencer_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides the system clock down to the sequencer's timing unit. While
// enabled it counts 0..TICK_DIV-1 and raises o_tick_en during the clock in
// which the count sits on its last value, so the edge closing that clock is
// a tick edge.
//
// Ports:
//   clk       system clock
//   reset     synchronous active-high reset
//   i_clear   synchronous clear of the count (held while the sequencer idles)
//   i_enable  count enable (sequencer running)
//   o_tick_en one tick is due at the next rising edge
// ---------------------------------------------------------------------------
module tick_prescaler
  import motion_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick_en
);

  // A one-bit counter is kept even for TICK_DIV == 1 so the width is legal;
  // in that case LAST is zero and every enabled clock is a tick.
  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  assign o_tick_en = i_enable && (r_count == LAST);

  // Free-running modulo-TICK_DIV count while enabled, parked at zero when
  // cleared so the first tick after a restart lands TICK_DIV clocks later.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      if (r_count == LAST) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/motion_phase_sequencer.sv
// ---------------------------------------------------------------------------
// motion_phase_sequencer
// Plays out the winning axis profile in real time. A profile is four
// cumulative phase end boundaries t0..t3 (in ticks) plus a five-word
// parameter set. On an accepted start the profile is latched and the
// sequencer walks through phases 0..3 against a tick counter, publishing
// the current phase, total and per-phase elapsed ticks, and the latched
// parameters to the step generators.
//
// Ports:
//   clk            system clock
//   reset          synchronous active-high reset
//   start          run the profile on timing/params (only looked at in IDLE)
//   abort          stop the running move at the next edge, no finish pulse
//   timing[0:3]    cumulative phase end boundaries t0..t3
//   params[0:4]    parameter set belonging to timing
//   active_params  parameters latched at accept, stable for the move
//   phase          0..3 while running, 7 while idle
//   elapsed        ticks since move start (holds t3 after completion)
//   phase_elapsed  ticks since the current phase began
//   phase_strobe   one-cycle pulse on each phase entry, including the first
//   busy           high while running
//   finish         one-cycle pulse on normal completion
//   error          one-cycle pulse when a non-monotonic profile is rejected
// ---------------------------------------------------------------------------
module motion_phase_sequencer
  import motion_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int TW       = TW_DEFAULT,
  parameter int PW       = PW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [TW-1:0] timing        [0:3],
  input  logic [PW-1:0] params        [0:4],
  output logic [PW-1:0] active_params [0:4],
  output logic [2:0]    phase,
  output logic [TW-1:0] elapsed,
  output logic [TW-1:0] phase_elapsed,
  output logic          phase_strobe,
  output logic          busy,
  output logic          finish,
  output logic          error
);

  seq_state_t    r_state;
  seq_state_t    w_state_nxt;

  logic [TW-1:0] r_timing      [0:3];
  logic [TW-1:0] w_timing_nxt  [0:3];
  logic [PW-1:0] r_params      [0:4];
  logic [PW-1:0] w_params_nxt  [0:4];

  logic [2:0]    r_phase;
  logic [2:0]    w_phase_nxt;
  logic [TW-1:0] r_elapsed;
  logic [TW-1:0] w_elapsed_nxt;
  logic [TW-1:0] r_phase_elapsed;
  logic [TW-1:0] w_phase_elapsed_nxt;
  logic          r_strobe;
  logic          w_strobe_nxt;
  logic          r_finish;
  logic          w_finish_nxt;
  logic          r_error;
  logic          w_error_nxt;

  logic          w_run;
  logic          w_tick_en;
  logic          w_monotonic;
  logic [TW-1:0] w_elapsed_inc;
  logic [2:0]    w_first_phase;
  logic [2:0]    w_tick_phase;

  // The phase for a given elapsed count is the lowest boundary still ahead
  // of it. Scanning from the top down leaves the lowest match in place,
  // which is what skips zero-length phases without any special casing.
  function automatic logic [2:0] find_phase(input logic [TW-1:0] t [0:3],
                                            input logic [TW-1:0] v);
    logic [2:0] p;
    p = PH_IDLE;
    for (int i = 3; i >= 0; i--) begin
      if (v < t[i]) begin
        p = 3'(i);
      end
    end
    return p;
  endfunction

  assign w_run         = (r_state == ST_RUN);
  assign w_monotonic   = (timing[0] <= timing[1]) &&
                         (timing[1] <= timing[2]) &&
                         (timing[2] <= timing[3]);
  assign w_elapsed_inc = r_elapsed + TW'(1);
  assign w_first_phase = find_phase(timing, '0);
  assign w_tick_phase  = find_phase(r_timing, w_elapsed_inc);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (!w_run),
    .i_enable  (w_run),
    .o_tick_en (w_tick_en)
  );

  // Next-state and next-output logic. Everything holds by default and the
  // three pulse outputs default low so they can only last one cycle.
  // A rejected start touches nothing but the error pulse; a zero-length
  // profile is latched and completes immediately without entering RUN.
  // In RUN, abort wins over a coincident completion tick.
  always_comb begin
    w_state_nxt         = r_state;
    w_timing_nxt        = r_timing;
    w_params_nxt        = r_params;
    w_phase_nxt         = r_phase;
    w_elapsed_nxt       = r_elapsed;
    w_phase_elapsed_nxt = r_phase_elapsed;
    w_strobe_nxt        = 1'b0;
    w_finish_nxt        = 1'b0;
    w_error_nxt         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (!w_monotonic) begin
            w_error_nxt = 1'b1;
          end else begin
            w_timing_nxt        = timing;
            w_params_nxt        = params;
            w_elapsed_nxt       = '0;
            w_phase_elapsed_nxt = '0;
            if (timing[3] == '0) begin
              w_finish_nxt = 1'b1;
            end else begin
              w_state_nxt  = ST_RUN;
              w_phase_nxt  = w_first_phase;
              w_strobe_nxt = 1'b1;
            end
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_phase_nxt = PH_IDLE;
        end else if (w_tick_en) begin
          w_elapsed_nxt = w_elapsed_inc;
          if (w_elapsed_inc == r_timing[3]) begin
            w_state_nxt  = ST_IDLE;
            w_phase_nxt  = PH_IDLE;
            w_finish_nxt = 1'b1;
          end else begin
            w_phase_nxt = w_tick_phase;
            if (w_tick_phase != r_phase) begin
              w_strobe_nxt        = 1'b1;
              w_phase_elapsed_nxt = '0;
            end else begin
              w_phase_elapsed_nxt = r_phase_elapsed + TW'(1);
            end
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = PH_IDLE;
      end
    endcase
  end

  // Register bank. Reset returns every output to its idle value, which also
  // silently drops a move in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_phase         <= PH_IDLE;
      r_elapsed       <= '0;
      r_phase_elapsed <= '0;
      r_strobe        <= 1'b0;
      r_finish        <= 1'b0;
      r_error         <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_timing[i] <= '0;
      end
      for (int i = 0; i < 5; i++) begin
        r_params[i] <= '0;
      end
    end else begin
      r_state         <= w_state_nxt;
      r_phase         <= w_phase_nxt;
      r_elapsed       <= w_elapsed_nxt;
      r_phase_elapsed <= w_phase_elapsed_nxt;
      r_strobe        <= w_strobe_nxt;
      r_finish        <= w_finish_nxt;
      r_error         <= w_error_nxt;
      for (int i = 0; i < 4; i++) begin
        r_timing[i] <= w_timing_nxt[i];
      end
      for (int i = 0; i < 5; i++) begin
        r_params[i] <= w_params_nxt[i];
      end
    end
  end

  assign active_params = r_params;
  assign phase         = r_phase;
  assign elapsed       = r_elapsed;
  assign phase_elapsed = r_phase_elapsed;
  assign phase_strobe  = r_strobe;
  assign busy          = w_run;
  assign finish        = r_finish;
  assign error         = r_error;

endmodule

// File: tb/tb_motion_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_motion_phase_sequencer
// Two sequencer instances (TICK_DIV = 1 and TICK_DIV = 3) share timing,
// params, abort and reset; sel picks which one receives start and which one
// is observed. Expected behaviour comes from a closed-form model: cycle k
// after accept has elapsed = min(k / TICK_DIV, t3) and the phase is the
// first boundary still ahead of elapsed.
// ---------------------------------------------------------------------------
module tb_motion_phase_sequencer;
  import motion_pkg::*;

  typedef struct packed {
    logic [2:0]  ph;
    logic        busy;
    logic        stb;
    logic        fin;
    logic        err;
    logic [63:0] el;
    logic [63:0] pel;
  } snap_t;

  localparam snap_t RESET_SNAP = '{ph: 3'd7, default: '0};

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        sel;
  timing_vec_t timing_in;
  param_vec_t  params_in;

  param_vec_t  ap1, ap3;
  logic [2:0]  ph1, ph3;
  logic [63:0] el1, el3, pel1, pel3;
  logic        stb1, stb3, busy1, busy3, fin1, fin3, err1, err3;

  snap_t        obs;
  logic [159:0] obs_pk;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  motion_phase_sequencer #(.TICK_DIV(1), .TW(64), .PW(32)) dut1 (
    .clk           (clk),
    .reset         (reset),
    .start         (start & ~sel),
    .abort         (abort),
    .timing        (timing_in),
    .params        (params_in),
    .active_params (ap1),
    .phase         (ph1),
    .elapsed       (el1),
    .phase_elapsed (pel1),
    .phase_strobe  (stb1),
    .busy          (busy1),
    .finish        (fin1),
    .error         (err1)
  );

  motion_phase_sequencer #(.TICK_DIV(3), .TW(64), .PW(32)) dut3 (
    .clk           (clk),
    .reset         (reset),
    .start         (start & sel),
    .abort         (abort),
    .timing        (timing_in),
    .params        (params_in),
    .active_params (ap3),
    .phase         (ph3),
    .elapsed       (el3),
    .phase_elapsed (pel3),
    .phase_strobe  (stb3),
    .busy          (busy3),
    .finish        (fin3),
    .error         (err3)
  );

  function automatic logic [159:0] pack(input param_vec_t p);
    return {p[0], p[1], p[2], p[3], p[4]};
  endfunction

  // Observation mux for whichever instance is under test.
  always_comb begin
    if (sel) begin
      obs    = {ph3, busy3, stb3, fin3, err3, el3, pel3};
      obs_pk = pack(ap3);
    end else begin
      obs    = {ph1, busy1, stb1, fin1, err1, el1, pel1};
      obs_pk = pack(ap1);
    end
  end

  // Reference model: phase for a given elapsed count.
  function automatic int phase_of(input timing_vec_t t, input longint e);
    for (int i = 0; i < 4; i++) begin
      if (e < longint'(t[i])) return i;
    end
    return 7;
  endfunction

  // Reference model: expected outputs k cycles after the accept edge.
  function automatic snap_t model(input timing_vec_t t, input int d, input int k);
    snap_t  s;
    longint e;
    longint t3;
    int     ph;
    s  = '0;
    t3 = longint'(t[3]);
    e  = longint'(k / d);
    if (e > t3) e = t3;
    s.el = 64'(e);
    if (longint'(k) >= t3 * d) begin
      s.ph  = 3'd7;
      s.fin = (longint'(k) == t3 * d);
    end else begin
      ph     = phase_of(t, e);
      s.ph   = 3'(ph);
      s.busy = 1'b1;
      s.pel  = 64'(e - ((ph == 0) ? 0 : longint'(t[ph-1])));
      s.stb  = (k == 0) || (phase_of(t, longint'((k - 1) / d)) != ph);
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a profile to one instance and pulse start through the accept edge.
  task automatic launch(input logic which, input timing_vec_t t,
                        input param_vec_t p, input logic ab);
    sel = which;
    #1;
    timing_in = t;
    params_in = p;
    abort     = ab;
    start     = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic rand_timing(output timing_vec_t t);
    longint unsigned acc;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      acc  = acc + longint'($urandom_range(0, 4));
      t[i] = 64'(acc);
    end
    if (t[3] == 64'd0) t[3] = 64'd1;
  endtask

  task automatic rand_params(output param_vec_t p);
    for (int i = 0; i < 5; i++) p[i] = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sel   = 1'b0;
    for (int i = 0; i < 4; i++) timing_in[i] = 64'd0;
    for (int i = 0; i < 5; i++) params_in[i] = 32'd0;
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_checks++;
      if (obs !== RESET_SNAP) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs dut=%0d actual=%h required=%h", s, obs, RESET_SNAP);
      end
      n_checks++;
      if (obs_pk !== 160'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_params dut=%0d actual=%h required=0", s, obs_pk);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_profile();
    timing_vec_t t;
    param_vec_t  p;
    snap_t       e, g;
    int          nstb;
    t = '{64'd2, 64'd5, 64'd7, 64'd10};
    p = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    launch(1'b0, t, p, 1'b0);
    nstb = 0;
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) tick();
      e = model(t, 1, k);
      g = obs;
      if (!e.busy) g.pel = '0;
      if (g.stb) nstb++;
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("[TB] FAIL profile_div1 k=%0d actual=%h required=%h", k, g, e);
      end
    end
    n_checks++;
    if (nstb !== 4) begin
      n_fail++;
      $display("[TB] FAIL profile_strobe_count actual=%0d required=4", nstb);
    end
  endtask

  task automatic test_skip();
    timing_vec_t t;
    param_vec_t  p;
    snap_t       e, g;
    logic [7:0]  stb_mask;
    t = '{64'd1, 64'd1, 64'd1, 64'd2};
    rand_params(p);
    launch(1'b1, t, p, 1'b0);
    stb_mask = '0;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) tick();
      e = model(t, 3, k);
      g = obs;
      if (!e.busy) g.pel = '0;
      stb_mask[k] = g.stb;
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("[TB] FAIL skip_div3 k=%0d actual=%h required=%h", k, g, e);
      end
    end
    n_checks++;
    if (stb_mask !== 8'b0000_1001) begin
      n_fail++;
      $display("[TB] FAIL skip_strobe_cycles actual=%b required=00001001", stb_mask);
    end
  endtask

  // Zero-length profile, then a rejected non-monotonic profile whose
  // parameters must not displace the ones latched by the zero-length start.
  task automatic test_zero_and_error();
    timing_vec_t t;
    param_vec_t  pz, pe;
    snap_t       g, req;
    t = '{64'd0, 64'd0, 64'd0, 64'd0};
    rand_params(pz);
    launch(1'b0, t, pz, 1'b0);
    req = '{ph: 3'd7, fin: 1'b1, default: '0};
    g = obs;
    g.pel = '0;
    n_checks++;
    if (g !== req) begin
      n_fail++;
      $display("[TB] FAIL zero_finish actual=%h required=%h", g, req);
    end
    n_checks++;
    if (obs_pk !== pack(pz)) begin
      n_fail++;
      $display("[TB] FAIL zero_params actual=%h required=%h", obs_pk, pack(pz));
    end
    tick();
    g = obs;
    g.pel = '0;
    n_checks++;
    if (g !== RESET_SNAP) begin
      n_fail++;
      $display("[TB] FAIL zero_after actual=%h required=%h", g, RESET_SNAP);
    end

    t = '{64'd5, 64'd3, 64'd7, 64'd9};
    rand_params(pe);
    launch(1'b0, t, pe, 1'b0);
    req = '{ph: 3'd7, err: 1'b1, default: '0};
    g = obs;
    g.pel = '0;
    n_checks++;
    if (g !== req) begin
      n_fail++;
      $display("[TB] FAIL error_pulse actual=%h required=%h", g, req);
    end
    n_checks++;
    if (obs_pk !== pack(pz)) begin
      n_fail++;
      $display("[TB] FAIL error_params actual=%h required=%h", obs_pk, pack(pz));
    end
    tick();
    g = obs;
    g.pel = '0;
    n_checks++;
    if (g !== RESET_SNAP) begin
      n_fail++;
      $display("[TB] FAIL error_after actual=%h required=%h", g, RESET_SNAP);
    end
  endtask

  // Start during RUN is ignored; abort stops without finish; then a reset
  // mid-move returns everything to reset values.
  task automatic test_ignore_abort_reset();
    timing_vec_t t, t2;
    param_vec_t  p, p2;
    snap_t       e, g, req;
    t  = '{64'd2, 64'd5, 64'd7, 64'd10};
    t2 = '{64'd1, 64'd2, 64'd3, 64'd4};
    rand_params(p);
    launch(1'b0, t, p, 1'b0);
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) tick();
      if (k == 5) start = 1'b0;
      e = model(t, 1, k);
      g = obs;
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("[TB] FAIL run_ignore_start k=%0d actual=%h required=%h", k, g, e);
      end
      if (k == 4) begin
        rand_params(p2);
        timing_in = t2;
        params_in = p2;
        start     = 1'b1;
      end
    end
    n_checks++;
    if (obs_pk !== pack(p)) begin
      n_fail++;
      $display("[TB] FAIL run_ignore_params actual=%h required=%h", obs_pk, pack(p));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    req = '{ph: 3'd7, el: 64'd6, default: '0};
    for (int k = 0; k < 2; k++) begin
      g = obs;
      g.pel = '0;
      n_checks++;
      if (g !== req) begin
        n_fail++;
        $display("[TB] FAIL abort_idle c=%0d actual=%h required=%h", k, g, req);
      end
      tick();
    end

    launch(1'b0, t, p, 1'b0);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (obs !== RESET_SNAP) begin
      n_fail++;
      $display("[TB] FAIL midmove_reset actual=%h required=%h", obs, RESET_SNAP);
    end
    n_checks++;
    if (obs_pk !== 160'd0) begin
      n_fail++;
      $display("[TB] FAIL midmove_reset_params actual=%h required=0", obs_pk);
    end
    tick();
  endtask

  // Start wins over a coincident abort in IDLE; abort in IDLE does nothing.
  task automatic test_start_with_abort();
    timing_vec_t t;
    param_vec_t  p;
    snap_t       e, g, req;
    t = '{64'd3, 64'd3, 64'd4, 64'd6};
    rand_params(p);
    launch(1'b0, t, p, 1'b1);
    e = model(t, 1, 0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("[TB] FAIL start_abort_accept actual=%h required=%h", obs, e);
    end
    abort = 1'b1;
    tick();
    req = '{ph: 3'd7, default: '0};
    for (int k = 0; k < 2; k++) begin
      g = obs;
      g.pel = '0;
      n_checks++;
      if (g !== req) begin
        n_fail++;
        $display("[TB] FAIL abort_in_idle c=%0d actual=%h required=%h", k, g, req);
      end
      tick();
    end
    abort = 1'b0;
  endtask

  // Parameters latched at accept survive arbitrary input churn until the
  // next accepted start.
  task automatic test_params();
    timing_vec_t t, tr;
    param_vec_t  p, p2, pr;
    snap_t       e, g;
    int          last;
    t = '{64'd1, 64'd3, 64'd3, 64'd5};
    p = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd55};
    launch(1'b1, t, p, 1'b0);
    last = 5 * 3 + 1;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) tick();
      e = model(t, 3, k);
      g = obs;
      if (!e.busy) g.pel = '0;
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("[TB] FAIL params_move k=%0d actual=%h required=%h", k, g, e);
      end
      n_checks++;
      if (obs_pk !== pack(p)) begin
        n_fail++;
        $display("[TB] FAIL params_stable k=%0d actual=%h required=%h", k, obs_pk, pack(p));
      end
      rand_timing(tr);
      rand_params(pr);
      timing_in = tr;
      params_in = pr;
    end
    rand_params(p2);
    launch(1'b1, t, p2, 1'b0);
    n_checks++;
    if (obs_pk !== pack(p2)) begin
      n_fail++;
      $display("[TB] FAIL params_reaccept actual=%h required=%h", obs_pk, pack(p2));
    end
    repeat (5 * 3 + 1) tick();
  endtask

  task automatic test_random();
    timing_vec_t t;
    param_vec_t  p;
    snap_t       e, g;
    int          d, last;
    logic        which;
    for (int m = 0; m < 16; m++) begin
      which = m[0];
      d     = which ? 3 : 1;
      rand_timing(t);
      rand_params(p);
      launch(which, t, p, 1'b0);
      last = int'(t[3]) * d + 1;
      for (int k = 0; k <= last; k++) begin
        if (k > 0) tick();
        e = model(t, d, k);
        g = obs;
        if (!e.busy) g.pel = '0;
        n_checks++;
        if (g !== e) begin
          n_fail++;
          $display("[TB] FAIL random m=%0d k=%0d actual=%h required=%h", m, k, g, e);
        end
      end
      n_checks++;
      if (obs_pk !== pack(p)) begin
        n_fail++;
        $display("[TB] FAIL random_params m=%0d actual=%h required=%h", m, obs_pk, pack(p));
      end
    end
  endtask

  initial begin
    test_reset();
    test_profile();
    test_skip();
    test_zero_and_error();
    test_ignore_abort_reset();
    test_start_with_abort();
    test_params();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
